// File: rtl/stream_demux.sv
// stream_demux: 1-to-n stream demultiplexer with valid/ready handshakes.
// Each input beat carries a destination select and is delivered to exactly
// one output port in arrival order, through a two-entry (head + skid)
// elastic buffer so that the outputs come straight from registers while the
// block still sustains one beat per cycle.
module stream_demux #(
    parameter  int switch_bits = 1,
    parameter  int data_width  = 8,
    localparam int n_cell      = 1 << switch_bits
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [switch_bits-1:0] in_sel,
    input  logic [data_width-1:0]  in_data,
    output logic [n_cell-1:0]      out_valid,
    input  logic [n_cell-1:0]      out_ready,
    output logic [data_width-1:0]  out_data,
    output logic [1:0]             occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [switch_bits-1:0] head_sel, head_sel_n;
    logic [data_width-1:0]  head_data, head_data_n;
    logic [switch_bits-1:0] skid_sel, skid_sel_n;
    logic [data_width-1:0]  skid_data, skid_data_n;
    logic                   accept;
    logic                   emit;

    // State and buffer registers; reset clears both entries so stale beats vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_sel  <= '0;
            head_data <= '0;
            skid_sel  <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_n;
            head_sel  <= head_sel_n;
            head_data <= head_data_n;
            skid_sel  <= skid_sel_n;
            skid_data <= skid_data_n;
        end
    end

    // Handshake outputs and next-state / buffer-update decode.
    always_comb begin
        state_n     = state;
        head_sel_n  = head_sel;
        head_data_n = head_data;
        skid_sel_n  = skid_sel;
        skid_data_n = skid_data;
        out_valid   = '0;
        out_data    = head_data;
        occupancy   = 2'd0;

        // Ready depends only on state (and reset), never on in_valid/out_ready.
        in_ready = !rst && (state != HOLD2);
        if (state != EMPTY) begin
            out_valid[head_sel] = 1'b1;
        end
        emit   = (state != EMPTY) && out_ready[head_sel];
        accept = in_valid && in_ready;

        case (state)
            EMPTY: begin
                occupancy = 2'd0;
                if (accept) begin
                    state_n     = HOLD1;
                    head_sel_n  = in_sel;
                    head_data_n = in_data;
                end
            end
            HOLD1: begin
                occupancy = 2'd1;
                if (accept && emit) begin
                    head_sel_n  = in_sel;
                    head_data_n = in_data;
                end else if (accept) begin
                    state_n     = HOLD2;
                    skid_sel_n  = in_sel;
                    skid_data_n = in_data;
                end else if (emit) begin
                    state_n = EMPTY;
                end
            end
            HOLD2: begin
                occupancy = 2'd2;
                if (emit) begin
                    state_n     = HOLD1;
                    head_sel_n  = skid_sel;
                    head_data_n = skid_data;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

endmodule
